// File: rtl/cn_layer_sched_pkg.sv
// Shared state encoding and per-layer cycle count for the check-node layer scheduler.
package cn_layer_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_ACC  = 3'd2,
    S_GAP  = 3'd3,
    S_WB   = 3'd4,
    S_NEXT = 3'd5,
    S_DONE = 3'd6
  } sched_state_t;

  // Cycles per layer with the message memory always ready: CLR + ACC + GAP + WB + NEXT.
  function automatic int layer_cycles(input int col_num);
    return 2 * col_num + 3;
  endfunction

endpackage

// File: rtl/sched_wrap_cnt.sv
// Counter with clear, enable and terminal-count flag; wraps to 0 after MAX, never exceeds it.
// One-cycle update latency; holds its value while i_en is low.
module sched_wrap_cnt #(
  parameter int WID = 4,
  parameter int MAX = 15
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clr,
  input  logic           i_en,
  output logic [WID-1:0] o_cnt,
  output logic           o_tc
);

  localparam logic [WID-1:0] MAX_V = WID'(MAX);

  assign o_tc = (o_cnt == MAX_V);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      o_cnt <= '0;
    else if (i_en)
      o_cnt <= o_tc ? '0 : o_cnt + WID'(1);
  end

endmodule

// File: rtl/cn_layer_sched.sv
// Layer/iteration scheduler for cn_s: CLR, ACC, GAP, WB, NEXT per layer; 2*COL_NUM+3 cycles/layer.
// i_rdy low stalls the column stream one cycle at a time; early stop via CN_LAYER_SCHED_EARLY_STOP_EN.
module cn_layer_sched
  import cn_layer_sched_pkg::*;
#(
  parameter int COL_CNT_WID = 7,
  parameter int COL_NUM     = 32,
  parameter int LAYER_NUM   = 4,
  parameter int MAX_ITER    = 10,
  parameter int LAYER_WID   = 2,
  parameter int ITER_WID    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_rdy,
  input  logic                   i_syn_ok,
  output logic                   o_busy,
  output logic                   o_cn_clr,
  output logic                   o_cn_vld,
  output logic                   o_wb_vld,
  output logic [COL_CNT_WID-1:0] o_col_cnt,
  output logic [LAYER_WID-1:0]   o_layer,
  output logic [ITER_WID-1:0]    o_iter,
  output logic                   o_done,
  output logic [ITER_WID-1:0]    o_iter_used
);

  sched_state_t state;
  logic col_tc, layer_tc, iter_tc;
  logic stop;
  logic col_en, col_clr, run_clr, layer_en, iter_en;

`ifdef CN_LAYER_SCHED_EARLY_STOP_EN
  assign stop = iter_tc | i_syn_ok;
`else
  logic unused_syn_ok;
  assign unused_syn_ok = i_syn_ok;
  assign stop = iter_tc;
`endif

  assign o_cn_vld = (state == S_ACC) & i_rdy;
  assign o_wb_vld = (state == S_WB) & i_rdy;

  assign col_en   = o_cn_vld | o_wb_vld;
  assign col_clr  = (state == S_CLR);
  assign run_clr  = (state == S_IDLE) & i_start;
  assign layer_en = (state == S_NEXT);
  assign iter_en  = (state == S_NEXT) & layer_tc & ~stop;

  // The column counter wraps to 0 on the last beat, which doubles as the GAP/NEXT entry value.
  sched_wrap_cnt #(.WID(COL_CNT_WID), .MAX(COL_NUM - 1)) u_col_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (col_clr),
    .i_en  (col_en),
    .o_cnt (o_col_cnt),
    .o_tc  (col_tc)
  );

  sched_wrap_cnt #(.WID(LAYER_WID), .MAX(LAYER_NUM - 1)) u_layer_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (run_clr),
    .i_en  (layer_en),
    .o_cnt (o_layer),
    .o_tc  (layer_tc)
  );

  sched_wrap_cnt #(.WID(ITER_WID), .MAX(MAX_ITER - 1)) u_iter_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (run_clr),
    .i_en  (iter_en),
    .o_cnt (o_iter),
    .o_tc  (iter_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_busy      <= 1'b0;
      o_cn_clr    <= 1'b0;
      o_done      <= 1'b0;
      o_iter_used <= '0;
    end else begin
      o_cn_clr <= 1'b0;
      o_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state       <= S_CLR;
            o_busy      <= 1'b1;
            o_cn_clr    <= 1'b1;
            o_iter_used <= '0;
          end
        end
        S_CLR:  state <= S_ACC;
        S_ACC:  if (i_rdy && col_tc) state <= S_GAP;
        S_GAP:  state <= S_WB;
        S_WB:   if (i_rdy && col_tc) state <= S_NEXT;
        S_NEXT: begin
          if (!layer_tc || !stop) begin
            state    <= S_CLR;
            o_cn_clr <= 1'b1;
          end else begin
            state       <= S_DONE;
            o_done      <= 1'b1;
            o_iter_used <= o_iter + ITER_WID'(1);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cn_layer_sched.sv
// Directed bench for cn_layer_sched with COL_NUM=4, LAYER_NUM=2, MAX_ITER=3.
module tb_cn_layer_sched;
  import cn_layer_sched_pkg::*;

  localparam int COL_CNT_WID = 7;
  localparam int COL_NUM     = 4;
  localparam int LAYER_NUM   = 2;
  localparam int MAX_ITER    = 3;
  localparam int LAYER_WID   = 2;
  localparam int ITER_WID    = 4;
  localparam int LC          = layer_cycles(COL_NUM);
  localparam int DONE_CYC    = 1 + MAX_ITER * LAYER_NUM * LC;
  localparam int NEVER       = 1000;

  logic                   i_clk, i_rst, i_start, i_rdy, i_syn_ok;
  logic                   o_busy, o_cn_clr, o_cn_vld, o_wb_vld, o_done;
  logic [COL_CNT_WID-1:0] o_col_cnt;
  logic [LAYER_WID-1:0]   o_layer;
  logic [ITER_WID-1:0]    o_iter, o_iter_used;

  cn_layer_sched #(
    .COL_CNT_WID (COL_CNT_WID),
    .COL_NUM     (COL_NUM),
    .LAYER_NUM   (LAYER_NUM),
    .MAX_ITER    (MAX_ITER),
    .LAYER_WID   (LAYER_WID),
    .ITER_WID    (ITER_WID)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_rdy       (i_rdy),
    .i_syn_ok    (i_syn_ok),
    .o_busy      (o_busy),
    .o_cn_clr    (o_cn_clr),
    .o_cn_vld    (o_cn_vld),
    .o_wb_vld    (o_wb_vld),
    .o_col_cnt   (o_col_cnt),
    .o_layer     (o_layer),
    .o_iter      (o_iter),
    .o_done      (o_done),
    .o_iter_used (o_iter_used)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Packed view: {busy, cn_clr, cn_vld, wb_vld, done, col[6:0], layer[1:0], iter[3:0]}
  logic [17:0] rec_vec [0:127];
  logic [3:0]  rec_used[0:127];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] pack_out();
    return {o_busy, o_cn_clr, o_cn_vld, o_wb_vld, o_done, o_col_cnt, o_layer, o_iter};
  endfunction

  // Expected outputs for cycle c of an unstalled, full-length decode.
  function automatic logic [17:0] exp_full(input int c);
    int k, p;
    logic busy, clr, cv, wv, dn;
    logic [6:0] col;
    logic [1:0] lay;
    logic [3:0] it;
    busy = 0; clr = 0; cv = 0; wv = 0; dn = 0; col = '0; lay = '0; it = '0;
    if (c >= 1 && c < DONE_CYC) begin
      k = (c - 1) / LC;
      p = (c - 1) % LC;
      busy = 1;
      clr  = (p == 0);
      cv   = (p >= 1) && (p <= COL_NUM);
      wv   = (p >= COL_NUM + 2) && (p <= 2 * COL_NUM + 1);
      if (cv) col = 7'(p - 1);
      else if (wv) col = 7'(p - COL_NUM - 2);
      lay = 2'(k % LAYER_NUM);
      it  = 4'(k / LAYER_NUM);
    end else if (c == DONE_CYC) begin
      busy = 1;
      dn   = 1;
      it   = 4'(MAX_ITER - 1);
    end
    return {busy, clr, cv, wv, dn, col, lay, it};
  endfunction

  function automatic int first_done(input int n);
    for (int c = 1; c <= n; c++)
      if (rec_vec[c][13]) return c;
    return -1;
  endfunction

  // i_start is sampled at edge 0; cycle c is the interval following edge c-1.
  task automatic run_seq(input int ncyc, input int low_at, input int low_len,
                         input int syn_at, input int rst_at, input bit extra);
    i_start = 1'b1; i_rdy = 1'b1; i_syn_ok = 1'b0; i_rst = 1'b0;
    @(posedge i_clk); #1;
    for (int c = 1; c <= ncyc; c++) begin
      i_start  = extra && (c % 7 == 3);
      i_rdy    = !((c >= low_at) && (c < low_at + low_len));
      i_syn_ok = (c >= syn_at);
      i_rst    = (c == rst_at);
      #1;
      rec_vec[c]  = pack_out();
      rec_used[c] = o_iter_used;
      @(posedge i_clk); #1;
    end
    i_start = 1'b0; i_rst = 1'b0; i_rdy = 1'b1; i_syn_ok = 1'b0;
  endtask

  initial begin
    int dc;
    i_rst = 1'b1; i_start = 1'b0; i_rdy = 1'b1; i_syn_ok = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset outputs", 32'(pack_out()), 32'd0);
    chk("reset iter_used", 32'(o_iter_used), 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Full unstalled run against the cycle model
    run_seq(DONE_CYC + 3, NEVER, 0, NEVER, NEVER, 1'b0);
    for (int c = 1; c <= DONE_CYC; c++)
      chk($sformatf("full cyc%0d", c), 32'(rec_vec[c]), 32'(exp_full(c)));
    chk("full done cycle", 32'(first_done(DONE_CYC + 3)), 32'(DONE_CYC));
    chk("full iter_used", 32'(rec_used[DONE_CYC]), 32'(MAX_ITER));
    chk("full iter_used held", 32'(rec_used[DONE_CYC + 3]), 32'(MAX_ITER));
    chk("full idle busy", 32'(rec_vec[DONE_CYC + 1][17]), 32'd0);

    // i_rdy low in cycles 3 and 4 of the first ACC
    run_seq(DONE_CYC + 4, 3, 2, NEVER, NEVER, 1'b0);
    chk("stall used cleared", 32'(rec_used[1]), 32'd0);
    chk("stall c2 vld/col", 32'({rec_vec[2][15], rec_vec[2][12:6]}), 32'({1'b1, 7'd0}));
    chk("stall c3 vld/col", 32'({rec_vec[3][15], rec_vec[3][12:6]}), 32'({1'b0, 7'd1}));
    chk("stall c4 vld/col", 32'({rec_vec[4][15], rec_vec[4][12:6]}), 32'({1'b0, 7'd1}));
    chk("stall c5 vld/col", 32'({rec_vec[5][15], rec_vec[5][12:6]}), 32'({1'b1, 7'd1}));
    chk("stall c7 vld/col", 32'({rec_vec[7][15], rec_vec[7][12:6]}), 32'({1'b1, 7'd3}));
    chk("stall c8 gap", 32'(rec_vec[8][15:14]), 32'd0);
    chk("stall c9 wb", 32'({rec_vec[9][14], rec_vec[9][12:6]}), 32'({1'b1, 7'd0}));
    chk("stall done cycle", 32'(first_done(DONE_CYC + 4)), 32'(DONE_CYC + 2));
    chk("stall iter_used", 32'(rec_used[DONE_CYC + 2]), 32'(MAX_ITER));

    // i_syn_ok from cycle 20: first last-layer NEXT is cycle 22
    run_seq(DONE_CYC + 3, NEVER, 0, 20, NEVER, 1'b0);
    dc = first_done(DONE_CYC + 3);
`ifdef CN_LAYER_SCHED_EARLY_STOP_EN
    chk("early done cycle", 32'(dc), 32'd23);
    chk("early iter_used", 32'(rec_used[23]), 32'd1);
`else
    chk("no-early done cycle", 32'(dc), 32'(DONE_CYC));
    chk("no-early iter_used", 32'(rec_used[DONE_CYC]), 32'(MAX_ITER));
`endif

    // Reset asserted in cycle 30
    run_seq(40, NEVER, 0, NEVER, 30, 1'b0);
    chk("rst c30 busy", 32'(rec_vec[30][17]), 32'd1);
    for (int c = 31; c <= 40; c++)
      chk($sformatf("rst idle cyc%0d", c), 32'({rec_vec[c], rec_used[c]}), 32'd0);
    chk("rst no done", 32'(first_done(40)), 32'hFFFF_FFFF);

    run_seq(DONE_CYC + 2, NEVER, 0, NEVER, NEVER, 1'b0);
    chk("post-rst done cycle", 32'(first_done(DONE_CYC + 2)), 32'(DONE_CYC));
    chk("post-rst iter_used", 32'(rec_used[DONE_CYC]), 32'(MAX_ITER));

    // Extra i_start pulses while busy must change nothing
    run_seq(DONE_CYC + 3, NEVER, 0, NEVER, NEVER, 1'b1);
    for (int c = 1; c <= DONE_CYC; c++)
      chk($sformatf("restart cyc%0d", c), 32'(rec_vec[c]), 32'(exp_full(c)));
    chk("restart done cycle", 32'(first_done(DONE_CYC + 3)), 32'(DONE_CYC));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
